// File: rtl/ahb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_arbiter_pkg
// Description : Shared AHB encodings, arbiter FSM states and burst-length
//               helper for the AHB bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Beat count of a fixed-length burst; SINGLE and INCR are open-ended (0).
    function automatic logic [4:0] burst_beats(input hburst_e burst);
        case (burst)
            WRAP4,  INCR4:  burst_beats = 5'd4;
            WRAP8,  INCR8:  burst_beats = 5'd8;
            WRAP16, INCR16: burst_beats = 5'd16;
            default:        burst_beats = 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational masked priority encoder. Requests at or above
//               ptr_i win first (lowest index among them); otherwise the
//               lowest requesting index wins. ptr_i == 0 is fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] win_masked;
    logic [IDX_W-1:0] win_any;
    logic             hit_masked;

    // Scan downward so the last hit kept is the lowest index in each group.
    always_comb begin
        win_masked = '0;
        win_any    = '0;
        hit_masked = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_any = IDX_W'(i);
                if (i >= int'(ptr_i)) begin
                    win_masked = IDX_W'(i);
                    hit_masked = 1'b1;
                end
            end
        end
        winner_o = hit_masked ? win_masked : win_any;
        valid_o  = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bus_arbiter
// Description : AHB bus arbiter. Registered one-hot grant, burst tracking so
//               handover only happens on the last beat of a fixed-length
//               burst, and grant hold for locked sequences.
//               Optional macro AHB_ARB_ROUND_ROBIN_EN selects rotating
//               priority; default build is fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk_i,
    input  logic                   hreset_i,
    input  logic [NUM_MASTERS-1:0] hbusreq_i,
    input  logic [NUM_MASTERS-1:0] hlock_i,
    input  logic [1:0]             htrans_i,
    input  logic [2:0]             hburst_i,
    input  logic                   hready_i,
    input  logic [1:0]             hresp_i,
    output logic [NUM_MASTERS-1:0] hgrant_o,
    output logic [3:0]             hmaster_o,
    output logic                   hmastlock_o
);

    localparam int c_idx_w = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [0:0] c_st_arb   = ARB;
    localparam logic [0:0] c_st_burst = BURST;
    localparam logic [NUM_MASTERS-1:0] c_default_grant = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [0:0]             state_q,     state_d;
    logic [3:0]             beats_q,     beats_d;
    logic [NUM_MASTERS-1:0] grant_q,     grant_d;
    logic [c_idx_w-1:0]     gidx_q,      gidx_d;
    logic [3:0]             hmaster_q,   hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [c_idx_w-1:0]     pick_ptr;
    logic [c_idx_w-1:0]     pick_winner;
    logic                   pick_valid;
    logic [c_idx_w-1:0]     winner;
    logic [4:0]             trans_len;
    logic                   fixed_len;
    logic                   owner_lock;
    logic                   arb_ok;

    arb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (c_idx_w)
    ) u_pick (
        .req_i    (hbusreq_i),
        .ptr_i    (pick_ptr),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [c_idx_w-1:0] rr_ptr_q, rr_ptr_d;

    // Advance priority past the master that just received a grant it asked for.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (arb_ok && pick_valid) begin
            rr_ptr_d = (pick_winner == c_idx_w'(NUM_MASTERS - 1)) ? '0
                                                                  : pick_winner + c_idx_w'(1);
        end
    end

    // Rotating-priority pointer register.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    // Decide whether the grant may move this cycle.
    always_comb begin
        trans_len  = burst_beats(hburst_e'(hburst_i));
        fixed_len  = (trans_len != 5'd0);
        owner_lock = hlock_i[gidx_q];
        winner     = pick_valid ? pick_winner : c_idx_w'(DEFAULT_MASTER);
        arb_ok     = !owner_lock &&
                     (((state_q == c_st_arb) && !((htrans_i == NONSEQ) && fixed_len)) ||
                      ((state_q == c_st_burst) && (beats_q == 4'd1)));
    end

    // Burst tracker; early termination and error abort return to ARB without reload.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        case (state_q)
            c_st_arb: begin
                if ((htrans_i == NONSEQ) && fixed_len && hready_i) begin
                    state_d = c_st_burst;
                    beats_d = 4'(trans_len - 5'd1);
                end
            end
            c_st_burst: begin
                if ((htrans_i == IDLE) || (htrans_i == NONSEQ)) begin
                    state_d = c_st_arb;
                    beats_d = 4'd0;
                end else if ((hresp_i != OKAY) && !hready_i) begin
                    state_d = c_st_arb;
                    beats_d = 4'd0;
                end else if ((htrans_i == SEQ) && hready_i) begin
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) state_d = c_st_arb;
                end
            end
            default: begin
                state_d = c_st_arb;
                beats_d = 4'd0;
            end
        endcase
    end

    // Next grant and address-phase ownership.
    always_comb begin
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (arb_ok) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            gidx_d          = winner;
        end
        if (hready_i) begin
            hmaster_d   = 4'(gidx_q);
            hmastlock_d = owner_lock;
        end
    end

    // State registers; reset drops any burst in flight.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q     <= c_st_arb;
            beats_q     <= 4'd0;
            grant_q     <= c_default_grant;
            gidx_q      <= c_idx_w'(DEFAULT_MASTER);
            hmaster_q   <= 4'(DEFAULT_MASTER);
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant_o    = grant_q;
    assign hmaster_o   = hmaster_q;
    assign hmastlock_o = hmastlock_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_bus_arbiter
// Description : Self-checking bench for ahb_bus_arbiter (4 masters, default
//               master 0). Expected grant/master/lock triples are queued as
//               each cycle's stimulus is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk_i      (clk),
        .hreset_i    (rst),
        .hbusreq_i   (hbusreq),
        .hlock_i     (hlock),
        .htrans_i    (htrans),
        .hburst_i    (hburst),
        .hready_i    (hready),
        .hresp_i     (hresp),
        .hgrant_o    (hgrant),
        .hmaster_o   (hmaster),
        .hmastlock_o (hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] eg, input logic [3:0] em, input logic el);
        check({tag, "_grant"},  32'(hgrant),    32'(eg));
        check({tag, "_master"}, 32'(hmaster),   32'(em));
        check({tag, "_lock"},   32'(hmastlock), 32'(el));
    endtask

    // Queue the expected post-edge outputs for the stimulus now on the pins,
    // clock once, then compare against the oldest queued entry.
    task automatic step(input string tag, input logic [3:0] eg, input logic [3:0] em, input logic el);
        logic [8:0] e;
        string      t;
        exp_q.push_back({eg, em, el});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_now(t, e[8:5], e[4:1], e[0]);
    endtask

    task automatic idle_bus();
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;
        hresp   = OKAY;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();

        // 1. Reset values, then an asynchronous reset in the middle of an INCR8.
        repeat (2) @(posedge clk);
        #1;
        check_now("rst_hold", 4'b0001, 4'd0, 1'b0);
        rst = 1'b0;
        step("rst_idle", 4'b0001, 4'd0, 1'b0);
        hbusreq = 4'b0010;
        step("t1_g1", 4'b0010, 4'd0, 1'b0);
        htrans = NONSEQ; hburst = INCR8;
        step("t1_b1", 4'b0010, 4'd1, 1'b0);
        htrans = SEQ;
        step("t1_b2", 4'b0010, 4'd1, 1'b0);
        #2 rst = 1'b1;
        #1 check_now("t1_async", 4'b0001, 4'd0, 1'b0);
        #2 rst = 1'b0;
        #1 check_now("t1_release", 4'b0001, 4'd0, 1'b0);
        hbusreq = 4'b0100;
        step("t1_discard", 4'b0100, 4'd0, 1'b0);

        // 2. Fixed priority pick and hmaster hold while hready is low.
        do_reset();
        hbusreq = 4'b0110;
        step("t2_grant", 4'b0010, 4'd0, 1'b0);
        hready = 1'b0;
        step("t2_wait", 4'b0010, 4'd0, 1'b0);
        hready = 1'b1;
        step("t2_own", 4'b0010, 4'd1, 1'b0);

        // 3. INCR4 by M1 with M2 requesting: handover only on the last beat.
        do_reset();
        hbusreq = 4'b0010;
        step("t3_g1", 4'b0010, 4'd0, 1'b0);
        htrans = NONSEQ; hburst = INCR4; hbusreq = 4'b0110;
        step("t3_beat1", 4'b0010, 4'd1, 1'b0);
        htrans = SEQ; hbusreq = 4'b0100;
        step("t3_beat2", 4'b0010, 4'd1, 1'b0);
        step("t3_beat3", 4'b0010, 4'd1, 1'b0);
        step("t3_beat4", 4'b0100, 4'd1, 1'b0);
        htrans = IDLE;
        step("t3_after", 4'b0100, 4'd2, 1'b0);

        // 4. INCR4 aborted by ERROR on beat 2.
        do_reset();
        hbusreq = 4'b0010;
        step("t4_g1", 4'b0010, 4'd0, 1'b0);
        htrans = NONSEQ; hburst = INCR4; hbusreq = 4'b0110;
        step("t4_beat1", 4'b0010, 4'd1, 1'b0);
        htrans = SEQ; hbusreq = 4'b0100; hresp = ERROR; hready = 1'b0;
        step("t4_err1", 4'b0010, 4'd1, 1'b0);
        htrans = IDLE; hready = 1'b1;
        step("t4_err2", 4'b0100, 4'd1, 1'b0);
        hresp = OKAY;

        // 5. Locked M0 keeps the grant against all requesters.
        do_reset();
        hlock = 4'b0001; hbusreq = 4'b1111;
        for (int i = 0; i < 10; i++) step("t5_locked", 4'b0001, 4'd0, 1'b1);
        hlock = 4'b0000; hbusreq = 4'b1110;
        step("t5_unlock", 4'b0010, 4'd0, 1'b0);

        // 6. All masters requesting with single transfers.
        do_reset();
        hbusreq = 4'b1111; htrans = NONSEQ; hburst = SINGLE;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        step("t6_rr0", 4'b0001, 4'd0, 1'b0);
        step("t6_rr1", 4'b0010, 4'd0, 1'b0);
        step("t6_rr2", 4'b0100, 4'd1, 1'b0);
        step("t6_rr3", 4'b1000, 4'd2, 1'b0);
        step("t6_rr4", 4'b0001, 4'd3, 1'b0);
`else
        for (int i = 0; i < 5; i++) step("t6_fixed", 4'b0001, 4'd0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
